// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the boot-time instruction memory loader.
// Frame layout: sync, length low, length high, data words, checksum.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Byte positions within a frame, counted from the sync byte.
    localparam int FRAME_OFS_LEN_LO = 1;
    localparam int FRAME_OFS_LEN_HI = 2;

    function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data_byte);
        return csum ^ data_byte;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, imem write port and core control out.
// The master modport is the loader side; slave is the surrounding system.
interface imem_loader_if #(
    parameter int AddrWidth = 32
);
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 imem_we;
    logic [AddrWidth-1:0] imem_waddr;
    logic [31:0]          imem_wdata;
    logic                 core_hold;
    logic                 load_done;
    logic                 load_err;
    logic [15:0]          words_loaded;

    modport master (
        input  rx_valid, rx_data,
        output imem_we, imem_waddr, imem_wdata, core_hold, load_done, load_err, words_loaded
    );

    modport slave (
        output rx_valid, rx_data,
        input  imem_we, imem_waddr, imem_wdata, core_hold, load_done, load_err, words_loaded
    );
endinterface

// File: rtl/imem_word_packer.sv
// Packs bytes LSB-first into 32-bit words; word_ready pulses the cycle
// after the 4th byte, while word still holds the completed value.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready,
    output logic [1:0]  byte_idx
);
    logic [7:0] lane_reg [4];
    logic [1:0] byte_idx_reg;
    logic       word_ready_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_in;
            // New bytes enter at the top lane and drift down toward [7:0].
            if (gi == 3) begin : g_top
                assign lane_in = byte_in;
            end else begin : g_mid
                assign lane_in = lane_reg[gi+1];
            end

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    lane_reg[gi] <= 8'h00;
                end else if (byte_valid) begin
                    lane_reg[gi] <= lane_in;
                end
            end

            assign word[8*gi +: 8] = lane_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_reg   <= 2'd0;
            word_ready_reg <= 1'b0;
        end else begin
            word_ready_reg <= 1'b0;
            if (clear) begin
                byte_idx_reg <= 2'd0;
            end else if (byte_valid) begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
                if (byte_idx_reg == 2'd3) begin
                    word_ready_reg <= 1'b1;
                end
            end
        end
    end

    assign word_ready = word_ready_reg;
    assign byte_idx   = byte_idx_reg;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses framed UART bytes, writes words to imem from address 0,
// verifies the XOR checksum and holds the core until a good image is in place.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         AddrWidth     = 32,
    parameter int         DepthWords    = 512,
    parameter logic [7:0] SyncByte      = SYNC_BYTE_DEFAULT,
    parameter int         TimeoutCycles = 1000000
) (
    input  logic           clk,
    input  logic           rst,
    imem_loader_if.master  bus
);
    localparam int TW = $clog2(TimeoutCycles + 1);

    loader_state_e        state_reg;
    logic [7:0]           len_lo_reg;
    logic [15:0]          len_reg;
    logic [7:0]           csum_reg;
    logic [15:0]          words_loaded_reg;
    logic [AddrWidth-1:0] waddr_reg;
    logic                 core_hold_reg;
    logic                 load_done_reg;
    logic                 load_err_reg;
    logic [TW-1:0]        idle_cnt_reg;

    logic        sync_seen;
    logic        pack_valid;
    logic        pack_ready;
    logic [1:0]  byte_idx;
    logic [31:0] pack_word;
    logic [15:0] len_next;
    logic        in_frame;
    logic        timed_out;

    // A sync byte only restarts from IDLE or ERR; inside a frame it is data.
    assign sync_seen  = bus.rx_valid && (bus.rx_data == SyncByte) &&
                        ((state_reg == S_IDLE) || (state_reg == S_ERR));
    assign pack_valid = bus.rx_valid && (state_reg == S_DATA);
    assign len_next   = (16'(bus.rx_data) << (8 * (FRAME_OFS_LEN_HI - FRAME_OFS_LEN_LO)))
                        | 16'(len_lo_reg);
    assign in_frame   = (state_reg == S_LEN0) || (state_reg == S_LEN1) ||
                        (state_reg == S_DATA) || (state_reg == S_CSUM);
    assign timed_out  = in_frame && !bus.rx_valid && (idle_cnt_reg == TW'(TimeoutCycles - 1));

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (sync_seen),
        .byte_valid (pack_valid),
        .byte_in    (bus.rx_data),
        .word       (pack_word),
        .word_ready (pack_ready),
        .byte_idx   (byte_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            len_lo_reg       <= 8'h00;
            len_reg          <= 16'h0000;
            csum_reg         <= 8'h00;
            words_loaded_reg <= 16'h0000;
            waddr_reg        <= '0;
            core_hold_reg    <= 1'b0;
            load_done_reg    <= 1'b0;
            load_err_reg     <= 1'b0;
            idle_cnt_reg     <= '0;
        end else begin
            load_done_reg <= 1'b0;
            if (in_frame) begin
                idle_cnt_reg <= bus.rx_valid ? '0 : idle_cnt_reg + 1'b1;
            end

            if (timed_out) begin
                state_reg    <= S_ERR;
                load_err_reg <= 1'b1;
            end else begin
                case (state_reg)
                    S_IDLE, S_ERR: begin
                        if (sync_seen) begin
                            state_reg        <= S_LEN0;
                            core_hold_reg    <= 1'b1;
                            load_err_reg     <= 1'b0;
                            words_loaded_reg <= 16'h0000;
                            csum_reg         <= 8'h00;
                            idle_cnt_reg     <= '0;
                        end
                    end
                    S_LEN0: begin
                        if (bus.rx_valid) begin
                            len_lo_reg <= bus.rx_data;
                            state_reg  <= S_LEN1;
                        end
                    end
                    S_LEN1: begin
                        if (bus.rx_valid) begin
                            len_reg <= len_next;
                            if (len_next > 16'(DepthWords)) begin
                                state_reg    <= S_ERR;
                                load_err_reg <= 1'b1;
                            end else if (len_next == 16'h0000) begin
                                state_reg <= S_CSUM;
                            end else begin
                                state_reg <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (bus.rx_valid) begin
                            csum_reg <= csum_update(csum_reg, bus.rx_data);
                            // Address and count are registered alongside the packer's word_ready.
                            if (byte_idx == 2'd3) begin
                                waddr_reg        <= AddrWidth'({words_loaded_reg, 2'b00});
                                words_loaded_reg <= words_loaded_reg + 16'd1;
                                if ((words_loaded_reg + 16'd1) == len_reg) begin
                                    state_reg <= S_CSUM;
                                end
                            end
                        end
                    end
                    S_CSUM: begin
                        if (bus.rx_valid) begin
                            if (bus.rx_data == csum_reg) begin
                                state_reg <= S_DONE;
                            end else begin
                                state_reg    <= S_ERR;
                                load_err_reg <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state_reg     <= S_IDLE;
                        load_done_reg <= 1'b1;
                        core_hold_reg <= 1'b0;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.imem_we      = pack_ready;
    assign bus.imem_wdata   = pack_word;
    assign bus.imem_waddr   = waddr_reg;
    assign bus.core_hold    = core_hold_reg;
    assign bus.load_done    = load_done_reg;
    assign bus.load_err     = load_err_reg;
    assign bus.words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum/length errors,
// back-to-back bytes, inter-byte timeout and mid-frame reset.
module tb_imem_loader;
    localparam int TIMEOUT = 40;

    typedef logic [7:0] bq_t[$];

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   done_cnt;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    bq_t  f;

    imem_loader_if #(.AddrWidth(32)) bus ();

    imem_loader #(
        .AddrWidth     (32),
        .DepthWords    (512),
        .SyncByte      (8'hA5),
        .TimeoutCycles (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wa.push_back(bus.imem_waddr);
            wd.push_back(bus.imem_wdata);
            $display("write addr=%08h data=%08h", bus.imem_waddr, bus.imem_wdata);
        end
        if (bus.load_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic send(input bq_t bytes, input bit gaps);
        foreach (bytes[i]) begin
            put(bytes[i]);
            if (gaps) idle(1);
        end
        idle(3);
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        done_cnt = 0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        done_cnt = 0;
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_we", bus.imem_we, 0);
        check("rst_waddr", bus.imem_waddr, 0);
        check("rst_wdata", bus.imem_wdata, 0);
        check("rst_hold", bus.core_hold, 0);
        check("rst_done", bus.load_done, 0);
        check("rst_err", bus.load_err, 0);
        check("rst_words", bus.words_loaded, 0);
        rst = 1'b0;
        idle(2);

        // Nominal two-word load with idle gaps between bytes.
        clear_mon();
        put(8'hA5);
        idle(1);
        check("nom_hold_after_sync", bus.core_hold, 1);
        f = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        foreach (f[i]) begin
            put(f[i]);
            idle(1);
        end
        put(8'hC1);
        idle(1);
        check("nom_hold_in_done", bus.core_hold, 1);
        check("nom_done_in_done", bus.load_done, 0);
        idle(1);
        check("nom_done_pulse", bus.load_done, 1);
        check("nom_hold_fall", bus.core_hold, 0);
        idle(1);
        check("nom_done_once", bus.load_done, 0);
        idle(2);
        check("nom_nwrites", wa.size(), 2);
        if (wa.size() == 2) begin
            check("nom_a0", wa[0], 32'h0);
            check("nom_d0", wd[0], 32'h00500093);
            check("nom_a1", wa[1], 32'h4);
            check("nom_d1", wd[1], 32'h00100113);
        end
        check("nom_words", bus.words_loaded, 2);
        check("nom_donecnt", done_cnt, 1);
        check("nom_err", bus.load_err, 0);
        $display("nominal load checked");

        // Bad checksum: words are written but the load is rejected.
        clear_mon();
        f = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC0};
        send(f, 1'b1);
        check("badcs_nwrites", wa.size(), 2);
        check("badcs_err", bus.load_err, 1);
        check("badcs_hold", bus.core_hold, 1);
        check("badcs_done", done_cnt, 0);
        clear_mon();
        f = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        send(f, 1'b1);
        check("recover_err", bus.load_err, 0);
        check("recover_done", done_cnt, 1);
        check("recover_hold", bus.core_hold, 0);
        check("recover_nwrites", wa.size(), 2);
        $display("bad checksum and recovery checked");

        // Oversize length 513 words.
        clear_mon();
        put(8'hA5);
        put(8'h01);
        put(8'h02);
        idle(1);
        check("over_err", bus.load_err, 1);
        check("over_hold", bus.core_hold, 1);
        idle(4);
        check("over_nwrites", wa.size(), 0);

        // Zero length with a wrong checksum, then with the right one.
        f = '{8'hA5, 8'h00, 8'h00, 8'h01};
        send(f, 1'b0);
        check("zero_bad_err", bus.load_err, 1);
        clear_mon();
        f = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send(f, 1'b0);
        check("zero_done", done_cnt, 1);
        check("zero_words", bus.words_loaded, 0);
        check("zero_nwrites", wa.size(), 0);
        check("zero_err", bus.load_err, 0);
        check("zero_hold", bus.core_hold, 0);
        $display("length boundaries checked");

        // Noise in IDLE, then a back-to-back frame whose first data byte is A5.
        clear_mon();
        put(8'h11);
        put(8'h22);
        idle(2);
        check("noise_hold", bus.core_hold, 0);
        f = '{8'hA5, 8'h02, 8'h00, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'hA5};
        send(f, 1'b0);
        check("b2b_nwrites", wa.size(), 2);
        if (wa.size() == 2) begin
            check("b2b_a0", wa[0], 32'h0);
            check("b2b_d0", wd[0], 32'h332211A5);
            check("b2b_a1", wa[1], 32'h4);
            check("b2b_d1", wd[1], 32'h77665544);
        end
        check("b2b_done", done_cnt, 1);
        check("b2b_err", bus.load_err, 0);
        $display("back-to-back frame checked");

        // Timeout after five data bytes.
        clear_mon();
        f = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        foreach (f[i]) put(f[i]);
        idle(TIMEOUT / 2);
        check("to_not_yet", bus.load_err, 0);
        idle(TIMEOUT);
        check("to_err", bus.load_err, 1);
        check("to_hold", bus.core_hold, 1);
        check("to_nwrites", wa.size(), 1);
        if (wa.size() == 1) check("to_d0", wd[0], 32'h04030201);
        $display("timeout checked");

        // Reset in the middle of DATA.
        clear_mon();
        f = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        foreach (f[i]) put(f[i]);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_hold", bus.core_hold, 0);
        check("mrst_err", bus.load_err, 0);
        check("mrst_words", bus.words_loaded, 0);
        check("mrst_we", bus.imem_we, 0);
        idle(5);
        check("mrst_nwrites", wa.size(), 1);
        clear_mon();
        f = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        send(f, 1'b0);
        check("post_nwrites", wa.size(), 2);
        if (wa.size() == 2) begin
            check("post_d0", wd[0], 32'h00500093);
            check("post_a1", wa[1], 32'h4);
            check("post_d1", wd[1], 32'h00100113);
        end
        check("post_done", done_cnt, 1);
        check("post_hold", bus.core_hold, 0);
        $display("mid-frame reset checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time programmer for the writable instruction memory.
- Receives a framed byte stream from the UART receiver and packs it into 32-bit little-endian words. Writes the words sequentially into imem starting at address 0 and checks an XOR checksum.
- Holds the core (fetch/PC) stalled from frame start until a successful load completes.
- Sits between uart_rx and the imem write port; a top-level mux uses core_hold to select loader vs. core.

Parameters:
- AddrWidth, 32, width of imem_waddr (byte address).
- DepthWords, 512, imem capacity in 32-bit words; longer frames are rejected.
- SyncByte, 8'hA5, frame start marker.
- TimeoutCycles, 1000000, maximum idle clocks between bytes inside a frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe; rx_data is valid.
- rx_data  input  8  received byte.
- imem_we  output  1  one-cycle imem write strobe.
- imem_waddr  output  AddrWidth  word-aligned byte address; bits [1:0] are always 0.
- imem_wdata  output  32  word to write.
- core_hold  output  1  stalls the core and selects the loader onto imem.
- load_done  output  1  one-cycle pulse on a successful load.
- load_err  output  1  sticky error flag.
- words_loaded  output  16  words written in the current or last frame.

Behaviour:
- Reset behaviour:
  - Single clock domain; reset is synchronous and active-high.
  - All outputs reset to 0; FSM goes to IDLE.
- Frame format: SyncByte, LEN_LO, LEN_HI (word count N, 16-bit little-endian), 4*N data bytes (each word little-endian), CSUM.
  - CSUM is the XOR of all data bytes only; sync and length bytes are excluded.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE:
  - Bytes other than SyncByte are ignored.
  - SyncByte → LEN0. On the next cycle: core_hold=1, load_err=0, words_loaded=0, checksum=0, byte index=0.
- LEN0 → LEN1 on a byte; the byte is latched as the length low byte.
- LEN1 on a byte:
  - N > DepthWords → ERR.
  - N == 0 → CSUM.
  - Otherwise → DATA.
- DATA:
  - Each byte is shifted in LSB-first (byte index 0 lands in [7:0]) and XORed into the checksum.
  - On the 4th byte of a word, the cycle after that rx_valid: imem_we=1 for exactly one cycle, imem_waddr=words_loaded<<2, imem_wdata=the packed word, and words_loaded increments in the same cycle.
  - After the Nth word's 4th byte → CSUM.
- CSUM on a byte:
  - Byte equals the running checksum → DONE.
  - Otherwise → ERR.
- DONE: lasts one cycle. load_done=1 and core_hold=0 from the following cycle; then IDLE.
- ERR:
  - load_err=1 and core_hold stays 1, so the core never runs a partial image.
  - SyncByte restarts a frame (clears load_err). rst also exits ERR.
- Timeout:
  - In LEN0, LEN1, DATA or CSUM, a counter counts clocks since the last rx_valid and clears on each byte.
  - Reaching TimeoutCycles → ERR.
- Boundary and ordering rules:
  - A SyncByte value received inside a frame is treated as data, not a restart.
  - rx_valid is never back-pressured. Consecutive-cycle strobes must be accepted, including a 4th byte arriving in the same cycle as a pending imem_we.
- imem_waddr never exceeds (DepthWords-1)*4; the counter does not wrap because of the length check.
- rst asserted mid-frame: next cycle IDLE, core_hold=0, nothing further written; already-written words remain in imem.

Decomposition:
- imem_loader_pkg holds:
  - loader_state_e enum;
  - SYNC_BYTE_DEFAULT;
  - frame byte offsets;
  - the checksum function.
- One sub-module, imem_word_packer. It contains the byte-to-word shift register, 2-bit byte index and word_ready pulse, with inputs clk, rst, clear, byte_valid, byte_in.
- The FSM, timeout counter and write-strobe logic stay in imem_loader.

Test Plan:
- Nominal 2-word load. Frame: A5 02 00 93 00 50 00 13 01 10 00 C1.
  - Writes: 0x00500093 @0x0, then 0x00100113 @0x4, each with one imem_we pulse.
  - load_done pulses once; words_loaded=2; core_hold falls the cycle after DONE.
- Bad checksum: same frame with CSUM=C0.
  - Both words are still written; load_err=1; core_hold stays 1; no load_done.
  - A following correct frame clears load_err and completes.
- Oversize length: A5 01 02 (N=513) → ERR immediately after LEN_HI; zero imem_we pulses.
- Zero length: A5 00 00 00 → load_done, words_loaded=0, no writes. A5 00 00 01 → ERR.
- Back-to-back bytes and noise:
  - Noise bytes 11 22 in IDLE before sync are ignored.
  - Frame bytes delivered on consecutive cycles produce correct writes; a data byte equal to A5 packs as data.
- Timeout and reset:
  - Stop sending after 5 data bytes; after TimeoutCycles clocks → ERR.
  - Separately, rst pulsed mid-DATA → outputs 0, IDLE; a subsequent full frame loads correctly.
